controle_sonar: RTL and testbench

CONTROLE_SONAR -- requirements
Module: controle_sonar

---
 rtl/sonar_pkg.sv | 20 ++
 rtl/contador_sat.sv | 40 ++++
 rtl/controle_sonar.sv | 128 ++++++++++++
 tb/tb_controle_sonar.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar measurement controller:
// FSM state codes, BCD distance width and default timing values.
// Imported by controle_sonar.
package sonar_pkg;

  localparam int BCD_W          = 12;
  localparam int ESTADO_W       = 4;
  localparam int PERIODO_PADRAO = 5_000_000; // 100 ms at 50 MHz
  localparam int TIMEOUT_PADRAO = 1_500_000; // 30 ms at 50 MHz

  typedef enum logic [ESTADO_W-1:0] {
    INICIAL   = 4'd0,
    DISPARA   = 4'd1,
    ESPERA    = 4'd2,
    ARMAZENA  = 4'd3,
    INTERVALO = 4'd4,
    FALHA     = 4'd5
  } estado_t;

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with synchronous clear; flags when LIMITE is reached.
// Latency: flag follows the count register (1 cycle after the enabling edge).
// No backpressure; clear has priority over enable.
module contador_sat #(
  parameter int WIDTH  = 8,
  parameter int LIMITE = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa_i,
  input  logic habilita_i,
  output logic saturado_o
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMITE);

  logic [WIDTH-1:0] conta_q, conta_d;

  // Next count: clear wins, otherwise count up and hold at the limit.
  always_comb begin
    conta_d = conta_q;
    if (limpa_i) begin
      conta_d = '0;
    end else if (habilita_i && (conta_q != LIM)) begin
      conta_d = conta_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

  assign saturado_o = (conta_q == LIM);

endmodule

// File: rtl/controle_sonar.sv
// Periodic ultrasonic measurement controller: trigger, wait with timeout, store BCD distance.
// Latency: pronto_sensor to nova_medida is 1 cycle; medir_sensor every PERIODO cycles.
// No backpressure; optional threshold alarm built when CONTROLE_SONAR_ALARME_EN is defined.
module controle_sonar
  import sonar_pkg::*;
#(
  parameter int PERIODO = PERIODO_PADRAO,
  parameter int TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ligar,
  input  logic             pronto_sensor,
  input  logic [BCD_W-1:0] medida_sensor,
  input  logic [BCD_W-1:0] limiar,
  output logic             medir_sensor,
  output logic             reinicia_sensor,
  output logic [BCD_W-1:0] medida,
  output logic             nova_medida,
  output logic             erro,
  output logic             alarme,
  output logic [3:0]       db_estado
);

  localparam int PER_W = $clog2(PERIODO + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  estado_t          estado_q, estado_d;
  logic             per_sat, to_sat;
  logic             medir_q, reinicia_q, nova_q, erro_q;
  logic [BCD_W-1:0] medida_q;

  // Counters restart on the edge that enters DISPARA, so the trigger cycle reads 0
  // and the next trigger lands exactly PERIODO cycles after this one.
  contador_sat #(.WIDTH(PER_W), .LIMITE(PERIODO - 1)) u_periodo (
    .clock      (clock),
    .reset      (reset),
    .limpa_i    (estado_d == DISPARA),
    .habilita_i (estado_q != INICIAL),
    .saturado_o (per_sat)
  );

  contador_sat #(.WIDTH(TO_W), .LIMITE(TIMEOUT - 1)) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .limpa_i    (estado_d == DISPARA),
    .habilita_i ((estado_q == DISPARA) || (estado_q == ESPERA)),
    .saturado_o (to_sat)
  );

  // Next-state logic; a late measurement finds the period counter saturated
  // and retriggers on the cycle after entering INTERVALO.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:   if (ligar) estado_d = DISPARA;
      DISPARA:   estado_d = ESPERA;
      ESPERA: begin
        if (pronto_sensor)   estado_d = ARMAZENA;
        else if (to_sat)     estado_d = FALHA;
      end
      ARMAZENA:  estado_d = INTERVALO;
      FALHA:     estado_d = INTERVALO;
      INTERVALO: begin
        if (!ligar)          estado_d = INICIAL;
        else if (per_sat)    estado_d = DISPARA;
      end
      default:   estado_d = INICIAL;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Pulses are decoded from the next state so they are flop outputs aligned with the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      medir_q    <= 1'b0;
      reinicia_q <= 1'b0;
      nova_q     <= 1'b0;
      erro_q     <= 1'b0;
      medida_q   <= '0;
    end else begin
      medir_q    <= (estado_d == DISPARA);
      reinicia_q <= (estado_d == FALHA);
      nova_q     <= (estado_d == ARMAZENA);
      if (estado_d == ARMAZENA) begin
        medida_q <= medida_sensor;
        erro_q   <= 1'b0;
      end else if (estado_d == FALHA) begin
        erro_q   <= 1'b1;
      end
    end
  end

`ifdef CONTROLE_SONAR_ALARME_EN
  logic alarme_q;

  // Alarm follows the stored distance; plain binary compare keeps BCD order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alarme_q <= 1'b0;
    end else if (estado_d == ARMAZENA) begin
      alarme_q <= (medida_sensor < limiar);
    end
  end

  assign alarme = alarme_q;
`else
  logic unused_limiar;
  assign unused_limiar = ^limiar;
  assign alarme        = 1'b0;
`endif

  assign medir_sensor    = medir_q;
  assign reinicia_sensor = reinicia_q;
  assign nova_medida     = nova_q;
  assign erro            = erro_q;
  assign medida          = medida_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_controle_sonar.sv
// Bench for controle_sonar: random sensor responses, reference timing model, event scoreboard.
// Second instance with a short period checks the late-measurement retrigger.
module tb_controle_sonar;

  localparam int PER  = 2000;
  localparam int TO   = 500;
  localparam int PER2 = 200;
`ifdef CONTROLE_SONAR_ALARME_EN
  localparam bit ALARME_ON = 1'b1;
`else
  localparam bit ALARME_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, ligar, pronto, ligar2, pronto2;
  logic [11:0] medida_sensor, limiar;
  logic        medir, reinicia, nova, erro, alarme;
  logic [11:0] medida;
  logic [3:0]  db_estado;
  logic        medir2, reinicia2, nova2, erro2, alarme2;
  logic [11:0] medida2;
  logic [3:0]  db_estado2;

  always #10 clock = ~clock;

  controle_sonar #(.PERIODO(PER), .TIMEOUT(TO)) u_dut (
    .clock(clock), .reset(reset), .ligar(ligar), .pronto_sensor(pronto),
    .medida_sensor(medida_sensor), .limiar(limiar), .medir_sensor(medir),
    .reinicia_sensor(reinicia), .medida(medida), .nova_medida(nova),
    .erro(erro), .alarme(alarme), .db_estado(db_estado)
  );

  controle_sonar #(.PERIODO(PER2), .TIMEOUT(TO)) u_dut2 (
    .clock(clock), .reset(reset), .ligar(ligar2), .pronto_sensor(pronto2),
    .medida_sensor(medida_sensor), .limiar(limiar), .medir_sensor(medir2),
    .reinicia_sensor(reinicia2), .medida(medida2), .nova_medida(nova2),
    .erro(erro2), .alarme(alarme2), .db_estado(db_estado2)
  );

  typedef struct {
    int          kind;   // 0 medir, 1 nova_medida, 2 reinicia
    int          cyc;
    logic [11:0] medida;
    logic        erro;
    logic        alarme;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp2_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  m;
  logic [11:0] mdl_medida = 12'h000;
  logic        mdl_erro   = 1'b0;
  logic        mdl_alarme = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic ev_t mk_ev(input int k, input int c, input logic [11:0] md,
                                input logic er, input logic al);
    ev_t e;
    e.kind = k; e.cyc = c; e.medida = md; e.erro = er; e.alarme = al;
    return e;
  endfunction

  function automatic logic [11:0] rand_bcd();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  // Inputs change 1 time unit after the edge of cycle k.
  task automatic goto_cycle(input int k);
    while (cyc < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_estado"},   32'(db_estado), 32'd0);
    chk({tag, "_medir"},    32'(medir),     32'd0);
    chk({tag, "_reinicia"}, 32'(reinicia),  32'd0);
    chk({tag, "_medida"},   32'(medida),    32'h000);
    chk({tag, "_nova"},     32'(nova),      32'd0);
    chk({tag, "_erro"},     32'(erro),      32'd0);
    chk({tag, "_alarme"},   32'(alarme),    32'd0);
  endtask

  // One measurement starting at medir cycle m. d<=0 means the sensor never answers.
  // Next trigger: PERIODO after this one, but never before the cycle after INTERVALO entry.
  task automatic do_meas(input int d, input logic [11:0] v, input bit cont);
    int entry, nxt;
    if (d > 0) begin
      mdl_medida = v;
      mdl_erro   = 1'b0;
      mdl_alarme = ALARME_ON && (v < limiar);
      exp_q.push_back(mk_ev(1, m + d + 1, mdl_medida, mdl_erro, mdl_alarme));
      entry = m + d + 2;
    end else begin
      mdl_erro = 1'b1;
      exp_q.push_back(mk_ev(2, m + TO, mdl_medida, mdl_erro, mdl_alarme));
      entry = m + TO + 1;
    end
    nxt = (m + PER > entry + 1) ? m + PER : entry + 1;
    if (cont) exp_q.push_back(mk_ev(0, nxt, 12'h000, 1'b0, 1'b0));
    if (!cont) begin
      goto_cycle(m + 10);
      ligar = 1'b0;
    end
    if (d > 0) begin
      goto_cycle(m + d);
      pronto = 1'b1;
      medida_sensor = v;
      goto_cycle(m + d + 1);
      pronto = 1'b0;
      medida_sensor = 12'($urandom);
    end
    if (cont) begin
      // stray pronto while idling between measurements must be ignored
      goto_cycle(entry + 1);
      pronto = 1'b1;
      medida_sensor = v ^ 12'h111;
      goto_cycle(entry + 2);
      pronto = 1'b0;
      m = nxt;
    end
  endtask

  // Scoreboard for the main instance.
  always @(negedge clock) begin : mon
    ev_t e;
    int  k;
    if (reset && (medir || nova || reinicia)) begin
      k = medir ? 0 : (nova ? 1 : 2);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", 32'(k), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind",  32'(k),   32'(e.kind));
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        if (e.kind != 0) begin
          chk("medida", 32'(medida), 32'(e.medida));
          chk("erro",   32'(erro),   32'(e.erro));
          chk("alarme", 32'(alarme), 32'(e.alarme));
        end
      end
    end
  end

  // Scoreboard for the short-period instance.
  always @(negedge clock) begin : mon2
    ev_t e;
    int  k;
    if (reset && (medir2 || nova2 || reinicia2)) begin
      k = medir2 ? 0 : (nova2 ? 1 : 2);
      if (exp2_q.size() == 0) begin
        chk("unexpected_pulse2_kind", 32'(k), 32'hFFFF_FFFF);
      end else begin
        e = exp2_q.pop_front();
        chk("event2_kind",  32'(k),   32'(e.kind));
        chk("event2_cycle", 32'(cyc), 32'(e.cyc));
        if (e.kind == 1) begin
          chk("medida2", 32'(medida2), 32'(e.medida));
          chk("alarme2", 32'(alarme2), 32'(e.alarme));
        end
        if (e.kind != 0) chk("erro2", 32'(erro2), 32'(e.erro));
      end
    end
  end

  initial begin
    int d, m2;
    reset = 1'b0; ligar = 1'b0; pronto = 1'b0; ligar2 = 1'b0; pronto2 = 1'b0;
    medida_sensor = 12'h000; limiar = 12'h050;
    repeat (3) @(posedge clock);
    #1;
    check_reset("rst");
    reset = 1'b1;
    goto_cycle(cyc + 3);

    ligar = 1'b1;
    m = cyc + 1;
    exp_q.push_back(mk_ev(0, m, 12'h000, 1'b0, 1'b0));
    do_meas(100, 12'h075, 1'b1);   // basic capture
    do_meas(0,   12'h000, 1'b1);   // timeout, medida holds
    do_meas(37,  12'h049, 1'b1);   // good again clears erro, below threshold
    do_meas(250, 12'h050, 1'b1);   // equal to threshold
    do_meas(499, 12'h123, 1'b1);   // pronto on the timeout cycle
    do_meas(1,   12'h999, 1'b1);   // earliest possible pronto
    for (int i = 0; i < 8; i++) begin
      d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 499));
      do_meas(d, rand_bcd(), 1'b1);
    end

    // ligar drops mid-measurement: completes, then stays idle
    do_meas(100, 12'h321, 1'b0);
    goto_cycle(m + 2500);
    chk("idle_after_drop", 32'(db_estado), 32'd0);

    // reset in the middle of ESPERA
    ligar = 1'b1;
    m = cyc + 1;
    exp_q.push_back(mk_ev(0, m, 12'h000, 1'b0, 1'b0));
    goto_cycle(m + 50);
    chk("in_espera", 32'(db_estado), 32'd2);
    reset = 1'b0;
    ligar = 1'b0;
    #1;
    check_reset("midrst");
    goto_cycle(cyc + 5);
    reset = 1'b1;
    goto_cycle(cyc + 1000);
    chk("idle_after_reset", 32'(db_estado), 32'd0);
    chk("medida_after_reset", 32'(medida), 32'h000);

    // short period, measurement longer than the period
    ligar2 = 1'b1;
    m2 = cyc + 1;
    exp2_q.push_back(mk_ev(0, m2, 12'h000, 1'b0, 1'b0));
    exp2_q.push_back(mk_ev(1, m2 + 301, 12'h040, 1'b0, ALARME_ON));
    exp2_q.push_back(mk_ev(0, m2 + 303, 12'h000, 1'b0, 1'b0));
    exp2_q.push_back(mk_ev(2, m2 + 303 + TO, 12'h040, 1'b1, ALARME_ON));
    goto_cycle(m2 + 300);
    pronto2 = 1'b1;
    medida_sensor = 12'h040;
    goto_cycle(m2 + 301);
    pronto2 = 1'b0;
    medida_sensor = 12'h000;
    goto_cycle(m2 + 310);
    ligar2 = 1'b0;
    goto_cycle(m2 + 1300);
    chk("idle2", 32'(db_estado2), 32'd0);

    chk("pending_events",  32'(exp_q.size()),  32'd0);
    chk("pending_events2", 32'(exp2_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
